// File: rtl/sync_pkg.sv
// Shared constants, types and parameter-legality helpers for the
// synchroniser/filter bank.
package sync_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_STAGES     = 2;
  localparam int DEF_FILTER_CNT = 4;

  // Per-channel registered outputs, bundled so the bank can index them.
  typedef struct packed {
    logic data;
    logic rise;
    logic fall;
  } chan_out_t;

  // Stability counter width: must hold 0..FILTER_CNT.
  function automatic int cnt_w(input int filter_cnt);
    return (filter_cnt < 1) ? 1 : $clog2(filter_cnt + 1);
  endfunction

  // Legal configuration: at least one channel, two sync flops, one filter cycle.
  function automatic bit params_ok(input int width, input int stages,
                                   input int filter_cnt);
    return (width >= 1) && (stages >= 2) && (filter_cnt >= 1);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchroniser chain, stability filter and
// registered rise/fall strobes. o_upd flags the edge on which the filtered
// level will change, so the bank can register its combined change strobe
// in the same cycle as the per-channel pulses.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = DEF_STAGES,
  parameter int   FILTER_CNT = DEF_FILTER_CNT,
  parameter logic RST_BIT    = 1'b0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_async,
  output chan_out_t o_chan,
  output logic      o_upd
);

  localparam int             CW       = cnt_w(FILTER_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CNT - 1);

  logic [STAGES-1:0] chain;
  logic              s;
  logic [CW-1:0]     cnt;
  logic              data;
  logic              rise;
  logic              fall;

  // Last flop of the chain is the first one considered metastability-safe.
  assign s = chain[STAGES-1];

  // The level moves once s has disagreed with it for FILTER_CNT edges in a row.
  assign o_upd = (s != data) && (cnt == CNT_LAST);

  // Synchroniser chain: shift the raw input in at the low end.
  always_ff @(posedge i_clk) begin
    if (!i_rst) chain <= {STAGES{RST_BIT}};
    else        chain <= {chain[STAGES-2:0], i_async};
  end

  // Stability filter and edge strobes; any return to the held level restarts the count.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt  <= '0;
      data <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= o_upd &  s;
      fall <= o_upd & ~s;
      if (s == data) begin
        cnt <= '0;
      end else if (o_upd) begin
        data <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_chan = '{data: data, rise: rise, fall: fall};

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchroniser bank: WIDTH independent channels, each with a
// flop chain, debounce filter and one-cycle edge strobes, plus a registered
// "any channel changed" strobe. Bits are synchronised individually; a
// multi-bit value crossing here is not coherent across channels.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               STAGES     = DEF_STAGES,
  parameter int               FILTER_CNT = DEF_FILTER_CNT,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async_data,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_change
);

  // Reject illegal configurations at elaboration.
  if (!params_ok(WIDTH, STAGES, FILTER_CNT)) begin : g_bad_params
    $error("sync_filter_bank: need WIDTH>=1, STAGES>=2, FILTER_CNT>=1");
  end

  chan_out_t [WIDTH-1:0] chan;
  logic      [WIDTH-1:0] upd;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RST_BIT    (RST_VAL[g])
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_async_data[g]),
      .o_chan  (chan[g]),
      .o_upd   (upd[g])
    );
    assign o_data[g] = chan[g].data;
    assign o_rise[g] = chan[g].rise;
    assign o_fall[g] = chan[g].fall;
  end

  // Registered from the update flags so it lines up with the per-channel pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst) o_change <= 1'b0;
    else        o_change <= |upd;
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench: two bank instances (2-stage/4-filter and
// 3-stage/1-filter) driven by the same stimulus, each compared every cycle
// against a window-based reference model, plus directed latency checks.
module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'h0;

  logic [3:0] a_data, a_rise, a_fall;
  logic       a_chg;
  logic [3:0] b_data, b_rise, b_fall;
  logic       b_chg;

  always #5 clk = ~clk;

  sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILTER_CNT(4), .RST_VAL(4'h0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_async_data(din),
    .o_data(a_data), .o_rise(a_rise), .o_fall(a_fall), .o_change(a_chg));

  sync_filter_bank #(.WIDTH(4), .STAGES(3), .FILTER_CNT(1), .RST_VAL(4'h0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_async_data(din),
    .o_data(b_data), .o_rise(b_rise), .o_fall(b_fall), .o_change(b_chg));

  // Edge strobes never last more than one cycle.
  a_rise_1: assert property (@(posedge clk) disable iff (!rst) (a_rise & $past(a_rise)) == 4'h0);
  a_fall_1: assert property (@(posedge clk) disable iff (!rst) (a_fall & $past(a_fall)) == 4'h0);
  b_rise_1: assert property (@(posedge clk) disable iff (!rst) (b_rise & $past(b_rise)) == 4'h0);
  b_fall_1: assert property (@(posedge clk) disable iff (!rst) (b_fall & $past(b_fall)) == 4'h0);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model. Input history gives the synchronised sample STAGES
  // edges late; the level flips once the last FILTER_CNT samples since the
  // previous flip/reset all disagree with it.
  int         cfg_stg[2] = '{2, 3};
  int         cfg_flt[2] = '{4, 1};
  logic [15:0] m_hist[2][4];
  logic [15:0] m_sh[2][4];
  int          m_valid[2][4];
  logic [3:0]  m_data[2], m_rise[2], m_fall[2];
  logic        m_chg[2];

  task automatic model_step();
    logic        s;
    logic [15:0] mask;
    bit          upd;
    for (int j = 0; j < 2; j++) begin
      m_rise[j] = 4'h0;
      m_fall[j] = 4'h0;
      for (int n = 0; n < 4; n++) begin
        if (!rst) begin
          m_hist[j][n]  = '0;
          m_sh[j][n]    = '0;
          m_valid[j][n] = 0;
          m_data[j][n]  = 1'b0;
        end else begin
          s = m_hist[j][n][cfg_stg[j]-1];
          m_hist[j][n] = {m_hist[j][n][14:0], din[n]};
          m_sh[j][n]   = {m_sh[j][n][14:0], s};
          m_valid[j][n]++;
          mask = (16'd1 << cfg_flt[j]) - 16'd1;
          upd = (m_valid[j][n] >= cfg_flt[j]) &&
                (((m_sh[j][n] ^ {16{m_data[j][n]}}) & mask) == mask);
          if (upd) begin
            m_rise[j][n]  = s;
            m_fall[j][n]  = !s;
            m_data[j][n]  = s;
            m_valid[j][n] = 0;
            m_sh[j][n]    = '0;
          end
        end
      end
      m_chg[j] = |(m_rise[j] | m_fall[j]);
    end
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare 1 time unit later.
  task automatic cyc(input logic r, input logic [3:0] d, input string tag);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".a.data"}, 32'(a_data), 32'(m_data[0]));
    chk({tag, ".a.rise"}, 32'(a_rise), 32'(m_rise[0]));
    chk({tag, ".a.fall"}, 32'(a_fall), 32'(m_fall[0]));
    chk({tag, ".a.chg"},  32'(a_chg),  32'(m_chg[0]));
    chk({tag, ".b.data"}, 32'(b_data), 32'(m_data[1]));
    chk({tag, ".b.rise"}, 32'(b_rise), 32'(m_rise[1]));
    chk({tag, ".b.fall"}, 32'(b_fall), 32'(m_fall[1]));
    chk({tag, ".b.chg"},  32'(b_chg),  32'(m_chg[1]));
  endtask

  int         la, lb, hi_cnt;
  logic [3:0] acc, r_seen, f_seen;
  logic       c_seen;
  logic [3:0] rnd;

  initial begin
    // 1: held in reset with all-ones input, then release
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'hF, "t1.rst");
    chk("t1.rst_data", 32'(a_data | a_rise | a_fall), 32'h0);
    la = -1; lb = -1; c_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 4'hF, "t1.rel");
      if (la < 0 && a_data == 4'hF) begin la = k; r_seen = a_rise; c_seen = a_chg; end
      if (lb < 0 && b_data == 4'hF) lb = k;
    end
    chk("t1.lat_a", 32'(la), 32'd6);
    chk("t1.lat_b", 32'(lb), 32'd4);
    chk("t1.rise_a", 32'(r_seen), 32'hF);
    chk("t1.chg_a", 32'(c_seen), 32'h1);

    // 2: ch0 step from settled zero
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'h0, "t2.settle");
    la = -1; lb = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 4'h1, "t2.step");
      if (la < 0 && a_data[0]) begin la = k; r_seen = a_rise; end
      if (lb < 0 && b_data[0]) lb = k;
    end
    chk("t2.lat_a", 32'(la), 32'd6);
    chk("t2.lat_b", 32'(lb), 32'd4);
    chk("t2.rise_a", 32'(r_seen), 32'h1);

    // 3: 3-cycle glitch on ch1 is rejected by the 4-cycle filter
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'h0, "t3.settle");
    acc = 4'h0;
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 4'h2, "t3.glitch"); acc |= a_data | a_rise | a_fall; end
    for (int i = 0; i < 10; i++) begin cyc(1'b1, 4'h0, "t3.after"); acc |= a_data | a_rise | a_fall; end
    chk("t3.quiet", 32'(acc), 32'h0);

    // 4: exactly 4-cycle pulse on ch1 passes, 4 cycles wide
    hi_cnt = 0; r_seen = 4'h0; f_seen = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'h2, "t4.pulse");
      hi_cnt += int'(a_data[1]); r_seen |= a_rise; f_seen |= a_fall;
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 4'h0, "t4.after");
      hi_cnt += int'(a_data[1]); r_seen |= a_rise; f_seen |= a_fall;
    end
    chk("t4.hi_cycles", 32'(hi_cnt), 32'd4);
    chk("t4.rise", 32'(r_seen), 32'h2);
    chk("t4.fall", 32'(f_seen), 32'h2);

    // 5: simultaneous ch2 rise and ch3 fall from settled 4'h8
    for (int i = 0; i < 12; i++) cyc(1'b1, 4'h8, "t5.settle");
    r_seen = 4'h0; f_seen = 4'h0; c_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'h4, "t5.swap");
      if (a_rise != 4'h0) begin r_seen = a_rise; f_seen = a_fall; c_seen = a_chg; end
    end
    chk("t5.rise", 32'(r_seen), 32'h4);
    chk("t5.fall", 32'(f_seen), 32'h8);
    chk("t5.chg",  32'(c_seen), 32'h1);

    // 6: reset lands mid-count, count restarts after release
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'h0, "t6.settle");
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'h1, "t6.count");
    acc = 4'h0;
    for (int i = 0; i < 3; i++) begin cyc(1'b0, 4'h1, "t6.rst"); acc |= a_data | a_rise | a_fall; end
    chk("t6.held", 32'(acc), 32'h0);
    la = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 4'h1, "t6.rel");
      if (la < 0 && a_data[0]) la = k;
    end
    chk("t6.lat_a", 32'(la), 32'd6);

    // Random: inputs hold for random stretches, occasional reset
    rnd = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rnd = 4'($urandom);
      cyc(($urandom_range(0, 59) != 0), rnd, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
